mpx_rom_ctrl: RTL and testbench
===============================

MPX_ROM_CTRL -- requirements
Module: mpx_rom_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the ROM address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the ROM word width.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rom_data  in  DATA_W  byte to load from the register block.
REQ-006 SHALL have port rom_wr_en  in  1  one-cycle load strobe qualifying rom_data.
REQ-007 SHALL have port load_clr  in  1  one-cycle pulse that rewinds the load pointer.
REQ-008 SHALL have port run_en  in  1  level enabling pilot playback.
REQ-009 SHALL have port step  in  32  phase increment per sample.
REQ-010 SHALL have port sample_en  in  1  one-cycle sample-rate strobe.
REQ-011 SHALL have port mem_addr  out  ADDR_W  single-port ROM RAM address.
REQ-012 SHALL have port mem_we  out  1  RAM write enable.
REQ-013 SHALL have port mem_wdata  out  DATA_W  RAM write data.
REQ-014 SHALL have port mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address.
REQ-015 SHALL have port pilot_sample  out  DATA_W  last table sample read.
REQ-016 SHALL have port pilot_valid  out  1  one-cycle strobe qualifying pilot_sample.
REQ-017 SHALL have port load_count  out  ADDR_W+1  bytes loaded since clear, saturating at 2^ADDR_W.
REQ-018 SHALL have port overrun  out  1  sticky flag: sample strobe dropped.

Function
REQ-019 SHALL hold states IDLE and RUN; IDLE->RUN when run_en=1, RUN->IDLE when run_en=0, each evaluated every cycle.
REQ-020 SHALL, in IDLE, hold the 32-bit phase accumulator at 0 and ignore sample_en (no read, no overrun).
REQ-021 SHALL, on rom_wr_en in any state, drive mem_we=1, mem_addr=wr_ptr, mem_wdata=rom_data in that same cycle.
REQ-022 SHALL increment wr_ptr modulo 2^ADDR_W after each write (1023 -> 0 at default).
REQ-023 SHALL increment load_count after each write, saturating at 2^ADDR_W.
REQ-024 SHALL, on load_clr, set wr_ptr=0 and load_count=0 next cycle; a simultaneous rom_wr_en writes at the old wr_ptr, after which wr_ptr=0 and load_count=0.
REQ-025 SHALL, on sample_en in RUN, latch rd_addr=phase[31:32-ADDR_W] and update phase<=phase+step (mod 2^32) in the same cycle.
REQ-026 SHALL issue the read in the sample_en cycle if rom_wr_en=0, driving mem_we=0, mem_addr=rd_addr.
REQ-027 SHALL give writes priority: if rom_wr_en and sample_en coincide, the read is pended and issued the following cycle.
REQ-028 SHALL hold at most one pending read; sample_en arriving while a read is pending is dropped (phase not advanced) and sets overrun=1.
REQ-029 SHALL, while a read is pending and rom_wr_en is asserted again, keep deferring the read until a cycle with rom_wr_en=0.
REQ-030 SHALL register mem_rdata into pilot_sample and assert pilot_valid for exactly one cycle, 2 cycles after the read issue cycle.
REQ-031 SHALL hold pilot_sample between reads; pilot_valid=0 otherwise.
REQ-032 SHALL complete an already-issued or pending read after RUN->IDLE; phase still clears to 0.
REQ-033 SHALL clear overrun only on reset or load_clr.
REQ-034 SHALL drive mem_addr=0 and mem_we=0 in cycles with no write or read issue.

Reset
REQ-035 SHALL, on reset assertion, asynchronously set state=IDLE, phase=0, wr_ptr=0, load_count=0, pending read cleared, pilot_sample=0, pilot_valid=0, overrun=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-036 SHALL abort any in-flight read on reset; no pilot_valid is produced for it after release.
REQ-037 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-038 SHALL cover: 4 rom_wr_en pulses with data 0x11,0x22,0x33,0x44 -> writes at addr 0..3, load_count=4.
REQ-039 SHALL cover: 1025 writes -> 1025th write at addr 0, load_count=1024; then load_clr -> load_count=0, next write at addr 0.
REQ-040 SHALL cover: run_en=1, step=0x00400000, three sample_en strobes -> reads at addr 0,1,2; each pilot_valid 2 cycles after its strobe.
REQ-041 SHALL cover: rom_wr_en and sample_en in cycle N -> write in N, read in N+1, pilot_valid in N+3, overrun=0.
REQ-042 SHALL cover: collision in cycle N plus sample_en in N+1 -> second strobe dropped, overrun=1, phase advanced by one step only.
REQ-043 SHALL cover: reset asserted in the cycle after a read issue -> no pilot_valid, all outputs at reset values.

Source files
------------

// File: rtl/mpx_rom_ctrl.sv
// Pilot-tone ROM controller: loads a wavetable into a single-port RAM and plays
// it back by phase accumulation, with writes taking priority over reads.
module mpx_rom_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_wr_en,
    input  logic              load_clr,
    input  logic              run_en,
    input  logic [31:0]       step,
    input  logic              sample_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pilot_sample,
    output logic              pilot_valid,
    output logic [ADDR_W:0]   load_count,
    output logic              overrun
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [31:0]       phase;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic              pend;
    logic              rd_d1;

    logic [ADDR_W-1:0] cur_addr;
    logic              accept;
    logic              drop;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;

    assign cur_addr   = phase[31 -: ADDR_W];
    assign accept     = (state == RUN) && sample_en && !pend;
    assign drop       = (state == RUN) && sample_en && pend;
    // A pending read always goes out first; a fresh strobe only when nothing is pending.
    assign issue      = !rom_wr_en && (pend || accept);
    assign issue_addr = pend ? rd_addr : cur_addr;

    // The RAM port is steered combinationally so writes and reads land in the request cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (rom_wr_en) begin
                mem_we    = 1'b1;
                mem_addr  = wr_ptr;
                mem_wdata = rom_data;
            end else if (issue) begin
                mem_addr  = issue_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            phase        <= '0;
            wr_ptr       <= '0;
            rd_addr      <= '0;
            pend         <= 1'b0;
            rd_d1        <= 1'b0;
            pilot_sample <= '0;
            pilot_valid  <= 1'b0;
            load_count   <= '0;
            overrun      <= 1'b0;
        end else begin
            state <= run_en ? RUN : IDLE;

            if (state == IDLE || !run_en) begin
                phase <= '0;
            end else if (accept) begin
                phase <= phase + step;
            end

            if (accept && rom_wr_en) begin
                pend    <= 1'b1;
                rd_addr <= cur_addr;
            end else if (pend && !rom_wr_en) begin
                pend    <= 1'b0;
            end

            // RAM returns data the cycle after the address; register it one more time.
            rd_d1       <= issue;
            pilot_valid <= rd_d1;
            if (rd_d1) begin
                pilot_sample <= mem_rdata;
            end

            if (load_clr) begin
                wr_ptr     <= '0;
                load_count <= '0;
                overrun    <= 1'b0;
            end else begin
                if (rom_wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (load_count != DEPTH) begin
                        load_count <= load_count + 1'b1;
                    end
                end
                if (drop) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mpx_rom_ctrl.sv
// Scoreboard bench for mpx_rom_ctrl: a cycle-level reference model predicts RAM
// port activity, counters and pilot samples; a negedge monitor compares.
module tb_mpx_rom_ctrl;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] rom_data = '0;
    logic          rom_wr_en = 1'b0;
    logic          load_clr = 1'b0;
    logic          run_en = 1'b0;
    logic [31:0]   step = '0;
    logic          sample_en = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pilot_sample;
    logic          pilot_valid;
    logic [AW:0]   load_count;
    logic          overrun;

    mpx_rom_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .rom_data(rom_data), .rom_wr_en(rom_wr_en),
        .load_clr(load_clr), .run_en(run_en), .step(step), .sample_en(sample_en),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pilot_sample(pilot_sample), .pilot_valid(pilot_valid),
        .load_count(load_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // External single-port RAM, synchronous read, reloaded with a known pattern on reset.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(i * 7 + 3);
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] wd; } bus_t;
    typedef struct packed { logic [AW:0] lc; logic ovr; } reg_t;
    typedef struct packed { int due; logic [DW-1:0] data; } pil_t;

    bus_t bus_q[$];
    reg_t reg_q[$];
    pil_t pil_q[$];

    int checks = 0;
    int errors = 0;
    bit chk = 0;

    // Reference model state
    logic [DW-1:0] mram [DEPTH];
    bit          m_run;
    logic [31:0] m_phase;
    int          m_wp, m_lc;
    bit          m_ovr;
    bit          m_pv;
    int          m_pa;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mram[i] = DW'(i * 7 + 3);
        m_run = 0; m_phase = 0; m_wp = 0; m_lc = 0; m_ovr = 0; m_pv = 0; m_pa = 0;
        pil_q.delete();
    endtask

    task automatic model_cycle(input bit wr, input logic [DW-1:0] wd, input bit clr,
                               input bit run, input logic [31:0] stp, input bit se);
        bus_t b;
        bit   accept, drop, iss;
        int   ia, top;
        reg_q.push_back('{lc: (AW+1)'(m_lc), ovr: m_ovr});
        b = '0;
        top = int'(m_phase >> (32 - AW));
        accept = m_run && se && !m_pv;
        drop   = m_run && se && m_pv;
        iss = 0; ia = 0;
        if (wr) begin
            b = '{we: 1'b1, addr: AW'(m_wp), wd: wd};
            mram[m_wp] = wd;
        end
        if (!wr && m_pv) begin
            iss = 1; ia = m_pa; m_pv = 0;
        end else if (!wr && accept) begin
            iss = 1; ia = top;
        end
        if (accept && wr) begin
            m_pv = 1; m_pa = top;
        end
        if (iss) begin
            b.addr = AW'(ia);
            pil_q.push_back('{due: cyc + 2, data: mram[ia]});
        end
        bus_q.push_back(b);
        if (accept) m_phase = m_phase + stp;
        if (!m_run || !run) m_phase = 0;
        m_run = run;
        if (wr) begin
            m_wp = (m_wp + 1) % DEPTH;
            if (m_lc < DEPTH) m_lc++;
        end
        if (drop) m_ovr = 1;
        if (clr) begin
            m_wp = 0; m_lc = 0; m_ovr = 0;
        end
    endtask

    task automatic cyc_step(input bit wr, input logic [DW-1:0] wd, input bit clr,
                            input bit run, input logic [31:0] stp, input bit se);
        @(posedge clk); #1;
        reset = 0;
        rom_wr_en = wr; rom_data = wd; load_clr = clr; run_en = run; step = stp; sample_en = se;
        model_cycle(wr, wd, clr, run, stp, se);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            reset = 1;
            rom_wr_en = 0; rom_data = 0; load_clr = 0; run_en = 0; step = 0; sample_en = 0;
            model_reset();
            reg_q.push_back('0);
            bus_q.push_back('0);
            chk = 1;
        end
        #1;
        check("rst_pilot_valid", int'(pilot_valid), 0);
        check("rst_pilot_sample", int'(pilot_sample), 0);
        check("rst_load_count", int'(load_count), 0);
        check("rst_mem_we", int'(mem_we), 0);
    endtask

    task automatic idle(input int n, input bit run);
        for (int k = 0; k < n; k++) cyc_step(0, 0, 0, run, step, 0);
    endtask

    always @(negedge clk) begin
        if (chk) begin
            bus_t eb;
            reg_t er;
            if (bus_q.size() == 0 || reg_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_underflow: cycle %0d", cyc);
            end else begin
                eb = bus_q.pop_front();
                er = reg_q.pop_front();
                checks++;
                if (mem_we !== eb.we || mem_addr !== eb.addr || mem_wdata !== eb.wd) begin
                    errors++;
                    $display("FAIL ram_port: got we=%0b addr=%0d wd=%h expected we=%0b addr=%0d wd=%h (cycle %0d)",
                             mem_we, mem_addr, mem_wdata, eb.we, eb.addr, eb.wd, cyc);
                end
                checks++;
                if (load_count !== er.lc || overrun !== er.ovr) begin
                    errors++;
                    $display("FAIL counters: got load_count=%0d overrun=%0b expected %0d/%0b (cycle %0d)",
                             load_count, overrun, er.lc, er.ovr, cyc);
                end
            end
            while (pil_q.size() > 0 && pil_q[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL pilot_missing: got none expected data=%h at cycle %0d", pil_q[0].data, pil_q[0].due);
                void'(pil_q.pop_front());
            end
            if (pilot_valid) begin
                checks++;
                if (pil_q.size() == 0 || pil_q[0].due != cyc) begin
                    errors++;
                    $display("FAIL pilot_unexpected: got data=%h at cycle %0d expected none", pilot_sample, cyc);
                end else if (pilot_sample !== pil_q[0].data) begin
                    errors++;
                    $display("FAIL pilot_data: got %h expected %h (cycle %0d)", pilot_sample, pil_q[0].data, cyc);
                end
                if (pil_q.size() > 0 && pil_q[0].due == cyc) void'(pil_q.pop_front());
            end
        end
    end

    initial begin
        logic [DW-1:0] pat [4];
        bit r;
        logic [31:0] s;
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        do_reset(3);

        // Four loads at addresses 0..3
        for (int i = 0; i < 4; i++) cyc_step(1, pat[i], 0, 0, 0, 0);
        idle(1, 0);
        check("load4_count", int'(load_count), 4);

        // Wraparound and saturation, then clear
        cyc_step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) cyc_step(1, DW'($urandom), 0, 0, 0, 0);
        idle(1, 0);
        check("sat_count", int'(load_count), DEPTH);
        cyc_step(0, 0, 1, 0, 0, 0);
        idle(1, 0);
        check("clr_count", int'(load_count), 0);
        cyc_step(1, 8'hA5, 0, 0, 0, 0);

        // Playback: three strobes at step 0x00400000 read 0,1,2
        step = 32'h0040_0000;
        idle(2, 1);
        for (int i = 0; i < 3; i++) begin
            cyc_step(0, 0, 0, 1, 32'h0040_0000, 1);
            idle(3, 1);
        end

        // Collision: write wins, read follows next cycle
        cyc_step(1, 8'h5C, 0, 1, 32'h0040_0000, 1);
        idle(4, 1);
        check("collide_ovr", int'(overrun), 0);

        // Collision plus a second strobe: dropped, overrun sticks
        cyc_step(1, 8'h6D, 0, 1, 32'h0040_0000, 1);
        cyc_step(0, 0, 0, 1, 32'h0040_0000, 1);
        idle(3, 1);
        check("drop_ovr", int'(overrun), 1);
        cyc_step(0, 0, 0, 1, 32'h0040_0000, 1);
        idle(3, 1);

        // Deferred read held off by back-to-back writes, then RUN->IDLE completion
        cyc_step(1, 8'h01, 0, 1, 32'h0040_0000, 1);
        cyc_step(1, 8'h02, 0, 1, 32'h0040_0000, 0);
        cyc_step(1, 8'h03, 0, 0, 32'h0040_0000, 0);
        idle(4, 0);

        // Reset one cycle after a read issue aborts it
        idle(2, 1);
        cyc_step(0, 0, 0, 1, 32'h0040_0000, 1);
        do_reset(2);
        idle(4, 0);

        // Randomized traffic
        r = 1; s = $urandom;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) r = !r;
            if ($urandom_range(0, 99) == 0) s = ($urandom_range(0, 1) != 0) ? $urandom : 32'h0040_0000 * $urandom_range(0, 7);
            cyc_step($urandom_range(0, 3) == 0, DW'($urandom), $urandom_range(0, 127) == 0,
                     r, s, $urandom_range(0, 2) == 0);
        end
        idle(6, 0);
        check("pilot_queue_drained", pil_q.size(), 0);
        @(negedge clk);
        chk = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
